// File: rtl/fractal_pass_scheduler.sv
// fractal_pass_scheduler
//   Sequences the fractal render loop for the iteration datapath, one frame at a
//   time. It counts accepted pixels to track the raster position. At every frame
//   boundary it can change the draw mode, the committed Julia constant and the
//   pass count. A render is one CLEAR frame followed by MAX_PASSES iteration frames.
//   Touch and home requests are latched at any time. They restart the render at the
//   next frame boundary.
// Ports
//   i_Clk, i_Reset        clock; asynchronous active-high reset
//   i_Px_Ack              datapath consumed one pixel this cycle
//   i_Touch_Valid/X/Y     pulse: render Julia set for touch point (clamped on-screen)
//   i_Mandel_Req          pulse: return to the Mandelbrot set
//   o_Draw                draw mode: 0 CLEAR, 1 MANDELBROT, 2 JULIA
//   o_cx, o_cy            committed Julia constant (pixel units)
//   o_Pass                completed iteration passes of the current render
//   o_Busy                0 only once all passes of the render are done
//   o_Frame_Done          one-cycle pulse after each frame boundary
module fractal_pass_scheduler #(
    parameter int H_PIXELS   = 800,
    parameter int V_PIXELS   = 480,
    parameter int MAX_PASSES = 64
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Px_Ack,
    input  logic       i_Touch_Valid,
    input  logic [9:0] i_Touch_X,
    input  logic [8:0] i_Touch_Y,
    input  logic       i_Mandel_Req,
    output logic [1:0] o_Draw,
    output logic [9:0] o_cx,
    output logic [8:0] o_cy,
    output logic [7:0] o_Pass,
    output logic       o_Busy,
    output logic       o_Frame_Done
);

    localparam logic [1:0] DRAW_CLEAR  = 2'd0;
    localparam logic [1:0] DRAW_MANDEL = 2'd1;
    localparam logic [1:0] DRAW_JULIA  = 2'd2;

    localparam logic [9:0] X_LAST   = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST   = 9'(V_PIXELS - 1);
    localparam logic [8:0] PASS_MAX = 9'(MAX_PASSES);

    typedef enum logic [1:0] {S_CLEAR, S_ITER, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_end;

    logic       pending;
    logic [1:0] target;
    logic [9:0] pend_x;
    logic [8:0] pend_y;

    logic [1:0] draw_nxt;
    logic [7:0] pass_nxt;
    logic [8:0] pass_inc;
    logic       commit;
    logic       clr_pend;

    // Raster position advances only on accepted pixels.
    assign frame_end = i_Px_Ack && (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            x <= '0;
            y <= '0;
        end else if (i_Px_Ack) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? 9'd0 : y + 9'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    // Request latch. A new request takes priority over the clear done by the
    // boundary. A request that arrives in the same cycle as a boundary is
    // therefore kept and acted on at the next boundary.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pending <= 1'b0;
            target  <= DRAW_MANDEL;
            pend_x  <= '0;
            pend_y  <= '0;
        end else if (i_Touch_Valid) begin
            pending <= 1'b1;
            target  <= DRAW_JULIA;
            pend_x  <= (i_Touch_X > X_LAST) ? X_LAST : i_Touch_X;
            pend_y  <= (i_Touch_Y > Y_LAST) ? Y_LAST : i_Touch_Y;
        end else if (i_Mandel_Req) begin
            pending <= 1'b1;
            target  <= DRAW_MANDEL;
        end else if (frame_end && clr_pend) begin
            pending <= 1'b0;
        end
    end

    // Next-state logic. It takes effect only on a frame boundary.
    always_comb begin
        state_nxt = state;
        draw_nxt  = o_Draw;
        pass_nxt  = o_Pass;
        commit    = 1'b0;
        clr_pend  = 1'b0;
        pass_inc  = {1'b0, o_Pass} + 9'd1;
        case (state)
            S_CLEAR: begin
                // Requests that arrive during CLEAR are picked up here.
                // No second clear frame is needed.
                state_nxt = S_ITER;
                draw_nxt  = target;
                commit    = (target == DRAW_JULIA);
                clr_pend  = 1'b1;
                pass_nxt  = '0;
            end
            S_ITER: begin
                if (pending) begin
                    state_nxt = S_CLEAR;
                    draw_nxt  = DRAW_CLEAR;
                    pass_nxt  = '0;
                end else begin
                    pass_nxt = (pass_inc >= PASS_MAX) ? PASS_MAX[7:0] : pass_inc[7:0];
                    if (pass_inc >= PASS_MAX) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (pending) begin
                    state_nxt = S_CLEAR;
                    draw_nxt  = DRAW_CLEAR;
                    pass_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                draw_nxt  = DRAW_CLEAR;
                pass_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= S_CLEAR;
            o_Draw       <= DRAW_CLEAR;
            o_cx         <= '0;
            o_cy         <= '0;
            o_Pass       <= '0;
            o_Frame_Done <= 1'b0;
        end else begin
            o_Frame_Done <= frame_end;
            if (frame_end) begin
                state  <= state_nxt;
                o_Draw <= draw_nxt;
                o_Pass <= pass_nxt;
                if (commit) begin
                    o_cx <= pend_x;
                    o_cy <= pend_y;
                end
            end
        end
    end

    assign o_Busy = (state != S_DONE);

endmodule

// File: tb/tb_fractal_pass_scheduler.sv
// Scoreboard bench for fractal_pass_scheduler.
// dut1 is a small raster (8x4, 3 passes) that covers sequencing, requests and reset.
// dut2 is an 800-pixel-wide raster (2 lines) that covers touch clamping.
// The stimulus pushes the expected record just before the accepted pixel that
// ends the frame. The monitor pops a record on every o_Frame_Done. Between frame
// boundaries it checks that the outputs hold the last popped record.
module tb_fractal_pass_scheduler;

    typedef struct packed {
        logic [1:0] draw;
        logic [9:0] cx;
        logic [8:0] cy;
        logic [7:0] pass;
        logic       busy;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack1 = 1'b0, tv1 = 1'b0, mr1 = 1'b0;
    logic [9:0] tx1 = '0;
    logic [8:0] ty1 = '0;
    logic       ack2 = 1'b0, tv2 = 1'b0;
    logic [9:0] tx2 = '0;
    logic [8:0] ty2 = '0;

    logic [1:0] draw1, draw2;
    logic [9:0] cx1, cx2;
    logic [8:0] cy1, cy2;
    logic [7:0] pass1, pass2;
    logic       busy1, busy2, fd1, fd2;

    rec_t q1[$];
    rec_t q2[$];
    logic stim_done = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fractal_pass_scheduler #(.H_PIXELS(8), .V_PIXELS(4), .MAX_PASSES(3)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_Px_Ack(ack1),
        .i_Touch_Valid(tv1), .i_Touch_X(tx1), .i_Touch_Y(ty1), .i_Mandel_Req(mr1),
        .o_Draw(draw1), .o_cx(cx1), .o_cy(cy1), .o_Pass(pass1),
        .o_Busy(busy1), .o_Frame_Done(fd1));

    fractal_pass_scheduler #(.H_PIXELS(800), .V_PIXELS(2), .MAX_PASSES(3)) dut2 (
        .i_Clk(clk), .i_Reset(rst), .i_Px_Ack(ack2),
        .i_Touch_Valid(tv2), .i_Touch_X(tx2), .i_Touch_Y(ty2), .i_Mandel_Req(1'b0),
        .o_Draw(draw2), .o_cx(cx2), .o_cy(cy2), .o_Pass(pass2),
        .o_Busy(busy2), .o_Frame_Done(fd2));

    function automatic rec_t mk(int d, int x, int y, int p, int b);
        rec_t r;
        r.draw = 2'(d); r.cx = 10'(x); r.cy = 9'(y); r.pass = 8'(p); r.busy = 1'(b);
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input rec_t a, input rec_t e,
                       input logic fa, input logic fe);
        tests++;
        if (a !== e || fa !== fe) begin
            fails++;
            $display("FAIL %s @%0t: got draw=%0d cx=%0d cy=%0d pass=%0d busy=%0d fd=%0d, want draw=%0d cx=%0d cy=%0d pass=%0d busy=%0d fd=%0d",
                     nm, $time, a.draw, a.cx, a.cy, a.pass, a.busy, fa,
                     e.draw, e.cx, e.cy, e.pass, e.busy, fe);
        end
    endtask

    rec_t cur1, cur2, e;
    always @(negedge clk) begin
        if (rst) begin
            cur1 = mk(0, 0, 0, 0, 1);
            cur2 = mk(0, 0, 0, 0, 1);
            chk("reset1", {draw1, cx1, cy1, pass1, busy1}, cur1, fd1, 1'b0);
            chk("reset2", {draw2, cx2, cy2, pass2, busy2}, cur2, fd2, 1'b0);
        end else begin
            if (fd1) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame_done1 @%0t: got pulse, want none", $time);
                end else begin
                    e = q1.pop_front();
                    chk("boundary1", {draw1, cx1, cy1, pass1, busy1}, e, fd1, 1'b1);
                    cur1 = e;
                end
            end else begin
                chk("steady1", {draw1, cx1, cy1, pass1, busy1}, cur1, fd1, 1'b0);
            end
            if (fd2) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame_done2 @%0t: got pulse, want none", $time);
                end else begin
                    e = q2.pop_front();
                    chk("boundary2", {draw2, cx2, cy2, pass2, busy2}, e, fd2, 1'b1);
                    cur2 = e;
                end
            end else begin
                chk("steady2", {draw2, cx2, cy2, pass2, busy2}, cur2, fd2, 1'b0);
            end
        end
        if (stim_done) begin
            tests++;
            if (q1.size() != 0 || q2.size() != 0) begin
                fails++;
                $display("FAIL missing_frame_done: got %0d/%0d records left, want 0/0",
                         q1.size(), q2.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic a, input logic tv, input int tx, input int ty,
                        input logic mr);
        ack1 = a; tv1 = tv; tx1 = 10'(tx); ty1 = 9'(ty); mr1 = mr;
        @(posedge clk); #1;
        ack1 = 1'b0; tv1 = 1'b0; mr1 = 1'b0;
    endtask

    task automatic acks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic boundary(input rec_t r);
        q1.push_back(r);
        step(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic full_frame(input rec_t r);
        acks(31);
        boundary(r);
    endtask

    task automatic step2(input logic tv, input int tx, input int ty);
        ack2 = 1'b1; tv2 = tv; tx2 = 10'(tx); ty2 = 9'(ty);
        @(posedge clk); #1;
        ack2 = 1'b0; tv2 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Clear frame then Mandelbrot passes 1..3, then DONE holds
        acks(10);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        acks(21);
        boundary(mk(1, 0, 0, 0, 1));
        full_frame(mk(1, 0, 0, 1, 1));
        full_frame(mk(1, 0, 0, 2, 1));
        full_frame(mk(1, 0, 0, 3, 0));
        full_frame(mk(1, 0, 0, 3, 0));

        // Home request from DONE restarts with a clear frame
        step(1'b1, 1'b0, 0, 0, 1'b1);
        acks(30);
        boundary(mk(0, 0, 0, 0, 1));
        full_frame(mk(1, 0, 0, 0, 1));

        // Touch mid ITER frame: mode holds to boundary, one clear, then Julia
        acks(10);
        step(1'b1, 1'b1, 5, 2, 1'b0);
        acks(20);
        boundary(mk(0, 0, 0, 0, 1));
        full_frame(mk(2, 5, 2, 0, 1));

        // Two touches during CLEAR fold into one clear frame, latest wins
        step(1'b1, 1'b0, 0, 0, 1'b1);
        acks(30);
        boundary(mk(0, 5, 2, 0, 1));
        acks(3);
        step(1'b1, 1'b1, 1, 1, 1'b0);
        acks(15);
        step(1'b1, 1'b1, 6, 3, 1'b0);
        acks(11);
        boundary(mk(2, 6, 3, 0, 1));
        full_frame(mk(2, 6, 3, 1, 1));

        // Touch and home on the same cycle: touch wins
        step(1'b1, 1'b1, 4, 1, 1'b1);
        acks(30);
        boundary(mk(0, 6, 3, 0, 1));
        full_frame(mk(2, 4, 1, 0, 1));

        // Touch on the boundary cycle is acted on one frame later
        acks(31);
        q1.push_back(mk(2, 4, 1, 1, 1));
        step(1'b1, 1'b1, 7, 3, 1'b0);
        full_frame(mk(0, 4, 1, 0, 1));
        full_frame(mk(2, 7, 3, 0, 1));

        // Reset mid-frame with acks held; raster restarts, idle cycles stall it
        acks(13);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        acks(20);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
        acks(11);
        boundary(mk(1, 0, 0, 0, 1));

        // Wide raster: out-of-range touch clamps to the last column/line
        step2(1'b1, 900, 500);
        for (int i = 0; i < 1598; i++) step2(1'b0, 0, 0);
        q2.push_back(mk(2, 799, 1, 0, 1));
        step2(1'b0, 0, 0);
        step2(1'b1, 123, 0);
        for (int i = 0; i < 1598; i++) step2(1'b0, 0, 0);
        q2.push_back(mk(0, 799, 1, 0, 1));
        step2(1'b0, 0, 0);
        for (int i = 0; i < 1599; i++) step2(1'b0, 0, 0);
        q2.push_back(mk(2, 123, 0, 0, 1));
        step2(1'b0, 0, 0);

        stim_done = 1'b1;
    end

endmodule
